lsu_ctrl: RTL

- Load/store unit in the MEM stage of the pipelined RISC-V core.
- Acts as the bus initiator for the data memory. It turns one pipeline load/store (funct3, address, store data) into a single word-aligned bus transaction with byte enables.
- Stalls the pipeline until the transaction completes, then returns extended load data.
- Flags misaligned accesses, illegal funct3 codes and response timeouts.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_align.sv | 75 +++++++
 rtl/lsu_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// error cause codes and the funct3 legality helper.
// Imported by lsu_align and lsu_ctrl.
package lsu_pkg;

  // RV32I load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // RV32I store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // err_cause encoding
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Loads accept the five RV32I load codes, stores only the three store codes.
  function automatic logic f3_is_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: request-side legality/alignment checks,
// byte enables and lane-replicated store data, and load-side lane extraction
// with sign/zero extension. Purely combinational, no handshake.
//   req_*  : live pipeline request (funct3, addr[1:0], we, store data)
//   be, wdata, f3_legal, misaligned : request-side results
//   ld_*   : latched load funct3/addr[1:0] plus the raw bus word -> ld_data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        f3_legal,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // funct3[1:0] encodes the access size for both loads and stores;
  // funct3[2] only selects zero-extension on loads.
  always_comb begin
    be    = 4'b1111;
    wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << req_addr_lo;
        wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    f3_legal   = f3_is_legal(req_we, req_funct3);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr_lo[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr_lo != 2'b00));
  end

  always_comb begin
    ld_byte = rdata[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    ld_data = rdata;
    case (ld_funct3)
      LB:      ld_data = {{24{ld_byte[7]}}, ld_byte};
      LH:      ld_data = {{16{ld_half[15]}}, ld_half};
      LBU:     ld_data = {24'h0, ld_byte};
      LHU:     ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: one pipeline load/store -> one word-aligned bus transaction.
// Latency: zero-wait responder gives 3 stall cycles for a load (rd_valid in the 4th), 2 for a store.
// Backpressure: stall held while waiting for bus_gnt (unbounded) and for bus_rvalid (bounded by TIMEOUT).
//   Pipeline side: mem_req/mem_we/funct3/addr/wr_data in; stall, rd_data/rd_valid, lsu_err/err_cause out.
//   Bus side: bus_req/bus_we/bus_addr/bus_be/bus_wdata out, bus_gnt/bus_rvalid/bus_rdata in.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,   // only 32 is supported
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255   // 1..255 WAIT cycles before a load is aborted
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  lsu_err,
  output logic [1:0]            err_cause,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  // WAIT exits after TIMEOUT cycles: the counter starts at 0 on entry,
  // so the last WAIT cycle is the one where it holds TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  lsu_state_t      state_q, state_d;
  logic [7:0]      cnt_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;

  logic [3:0]      req_be;
  logic [31:0]     req_wdata;
  logic            f3_legal;
  logic            misaligned;
  logic [31:0]     ld_data;
  logic            accept;

  lsu_align u_align (
    .req_funct3  (funct3),
    .req_addr_lo (addr[1:0]),
    .req_we      (mem_we),
    .req_wdata   (wr_data),
    .be          (req_be),
    .wdata       (req_wdata),
    .f3_legal    (f3_legal),
    .misaligned  (misaligned),
    .ld_funct3   (funct3_q),
    .ld_addr_lo  (addr_lo_q),
    .rdata       (bus_rdata),
    .ld_data     (ld_data)
  );

  // Only sampled in IDLE; in DONE mem_req still belongs to the finishing instruction.
  assign accept = mem_req && f3_legal && !misaligned;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_gnt) begin
          state_d = bus_we ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (bus_rvalid || (cnt_q == TO_LAST)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      lsu_err   <= 1'b0;
      err_cause <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      // Result/error outputs are single-cycle pulses by default.
      rd_valid  <= 1'b0;
      lsu_err   <= 1'b0;
      err_cause <= ERR_NONE;
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            if (!f3_legal) begin
              lsu_err   <= 1'b1;
              err_cause <= ERR_ILLEGAL;
            end else if (misaligned) begin
              lsu_err   <= 1'b1;
              err_cause <= ERR_MISALIGN;
            end else begin
              // bus_we/bus_addr/bus_wdata double as the latched request.
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              bus_be    <= req_be;
              bus_wdata <= req_wdata;
              funct3_q  <= funct3;
              addr_lo_q <= addr[1:0];
            end
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            cnt_q   <= 8'd0;
          end
        end
        WAIT: begin
          if (bus_rvalid) begin
            rd_data  <= ld_data;
            rd_valid <= 1'b1;
          end else if (cnt_q == TO_LAST) begin
            rd_data   <= '0;
            lsu_err   <= 1'b1;
            err_cause <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
